// File: rtl/traffic_phase_seq.sv
// ============================================================================
// Module   : traffic_phase_seq
// Purpose  : Intersection phase sequencer driven by prescaler ticks, with
//            pedestrian walk insertion and emergency all-red preemption.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_phase_seq #(
    parameter int TW       = 8,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 4,
    parameter int ALLRED_T = 2,
    parameter int PED_T    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_in,
    output logic          tick_en,
    input  logic          ped_req,
    output logic          ped_ack,
    input  logic          emerg,
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light,
    output logic          walk,
    output logic [3:0]    phase,
    output logic [TW-1:0] remain
);

    typedef enum logic [3:0] {
        INIT_RED = 4'd0,
        NS_G     = 4'd1,
        NS_Y     = 4'd2,
        RED1     = 4'd3,
        EW_G     = 4'd4,
        EW_Y     = 4'd5,
        RED2     = 4'd6,
        PED_WALK = 4'd7,
        EMERG    = 4'd8
    } state_t;

    localparam logic [TW-1:0] c_green_t  = TW'(GREEN_T);
    localparam logic [TW-1:0] c_yellow_t = TW'(YELLOW_T);
    localparam logic [TW-1:0] c_allred_t = TW'(ALLRED_T);
    localparam logic [TW-1:0] c_ped_t    = TW'(PED_T);
    localparam logic [TW-1:0] c_one      = TW'(1);
    localparam logic [2:0]    c_red      = 3'b100;
    localparam logic [2:0]    c_yellow   = 3'b010;
    localparam logic [2:0]    c_green    = 3'b001;

    state_t          r_state;
    logic [TW-1:0]   r_remain;
    logic            r_pending;
    logic            r_ped_ack;
    logic            r_tick_en;
    logic [2:0]      r_ns_light;
    logic [2:0]      r_ew_light;
    logic            r_walk;

    state_t          w_next_state;
    logic [TW-1:0]   w_next_remain;
    logic            w_done;
    logic            w_next_pending;
    logic            w_next_ack;
    logic [2:0]      w_next_ns;
    logic [2:0]      w_next_ew;
    logic            w_next_walk;

    // Last tick of a timed phase; unused in EMERG where ticks are ignored.
    assign w_done = tick_in && (r_remain == c_one);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            INIT_RED: if (w_done) w_next_state = emerg ? EMERG : NS_G;
            NS_G:     if (emerg || w_done) w_next_state = NS_Y;
            NS_Y:     if (w_done) w_next_state = emerg ? EMERG : RED1;
            RED1:     if (w_done) w_next_state = emerg ? EMERG : EW_G;
            EW_G:     if (emerg || w_done) w_next_state = EW_Y;
            EW_Y:     if (w_done) w_next_state = emerg ? EMERG : RED2;
            RED2: begin
                if (w_done) begin
                    if (emerg)          w_next_state = EMERG;
                    else if (r_pending) w_next_state = PED_WALK;
                    else                w_next_state = NS_G;
                end
            end
            PED_WALK: if (w_done) w_next_state = emerg ? EMERG : NS_G;
            EMERG:    if (!emerg) w_next_state = RED2;
            default:  w_next_state = INIT_RED;
        endcase
    end

    // Every transition reloads the full duration of the phase being entered.
    always_comb begin
        w_next_remain = r_remain;
        if (w_next_state != r_state) begin
            case (w_next_state)
                NS_G, EW_G:       w_next_remain = c_green_t;
                NS_Y, EW_Y:       w_next_remain = c_yellow_t;
                PED_WALK:         w_next_remain = c_ped_t;
                EMERG:            w_next_remain = '0;
                default:          w_next_remain = c_allred_t;
            endcase
        end else if (tick_in && r_state != EMERG) begin
            w_next_remain = r_remain - c_one;
        end
    end

    always_comb begin
        w_next_pending = r_pending;
        w_next_ack     = 1'b0;
        if (w_next_state == PED_WALK && r_state != PED_WALK) begin
            w_next_pending = 1'b0;
        end else if (ped_req && !r_pending && r_state != PED_WALK) begin
            w_next_pending = 1'b1;
            w_next_ack     = 1'b1;
        end
    end

    // Lamps are decoded from the next state so they change with phase.
    always_comb begin
        w_next_ns   = c_red;
        w_next_ew   = c_red;
        w_next_walk = 1'b0;
        case (w_next_state)
            NS_G:     w_next_ns   = c_green;
            NS_Y:     w_next_ns   = c_yellow;
            EW_G:     w_next_ew   = c_green;
            EW_Y:     w_next_ew   = c_yellow;
            PED_WALK: w_next_walk = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT_RED;
            r_remain   <= c_allred_t;
            r_pending  <= 1'b0;
            r_ped_ack  <= 1'b0;
            r_tick_en  <= 1'b0;
            r_ns_light <= c_red;
            r_ew_light <= c_red;
            r_walk     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_remain   <= w_next_remain;
            r_pending  <= w_next_pending;
            r_ped_ack  <= w_next_ack;
            r_tick_en  <= (w_next_state != EMERG);
            r_ns_light <= w_next_ns;
            r_ew_light <= w_next_ew;
            r_walk     <= w_next_walk;
        end
    end

    assign phase    = r_state;
    assign remain   = r_remain;
    assign ped_ack  = r_ped_ack;
    assign tick_en  = r_tick_en;
    assign ns_light = r_ns_light;
    assign ew_light = r_ew_light;
    assign walk     = r_walk;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_seq.sv
// ============================================================================
// Module   : tb_traffic_phase_seq
// Purpose  : Randomized bench for traffic_phase_seq against a table-driven
//            phase model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_seq;

    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick_in = 1'b0;
    logic          ped_req = 1'b0;
    logic          emerg = 1'b0;
    logic          tick_en;
    logic          ped_ack;
    logic [2:0]    ns_light;
    logic [2:0]    ew_light;
    logic          walk;
    logic [3:0]    phase;
    logic [TW-1:0] remain;

    int n_tests = 0;
    int n_fail  = 0;

    // Phase tables indexed by phase code 0..8.
    int dur_tbl[9]  = '{1, 3, 2, 1, 3, 2, 1, 2, 0};
    int succ_tbl[9] = '{1, 2, 3, 4, 5, 6, 1, 1, 6};

    int m_phase, m_remain;
    bit m_pend, m_ack, m_ten;

    traffic_phase_seq #(
        .TW(TW), .GREEN_T(3), .YELLOW_T(2), .ALLRED_T(1), .PED_T(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .tick_en(tick_en),
        .ped_req(ped_req), .ped_ack(ped_ack), .emerg(emerg),
        .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
        .phase(phase), .remain(remain)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_remain = 1;
        m_pend   = 0;
        m_ack    = 0;
        m_ten    = 0;
    endtask

    // One clock edge of the intersection rules.
    task automatic model_step(input bit tk, input bit pr, input bit em);
        int  np;
        bit  last_tick;
        np        = m_phase;
        last_tick = tk && (m_remain == 1);
        if (m_phase == 8) begin
            if (!em) np = 6;
        end else if ((m_phase == 1 || m_phase == 4) && em) begin
            np = m_phase + 1;
        end else if (last_tick) begin
            if (em)                       np = 8;
            else if (m_phase == 6 && m_pend) np = 7;
            else                          np = succ_tbl[m_phase];
        end

        if (np == 7 && m_phase != 7) begin
            m_pend = 0;
            m_ack  = 0;
        end else if (pr && !m_pend && m_phase != 7) begin
            m_pend = 1;
            m_ack  = 1;
        end else begin
            m_ack = 0;
        end

        if (np != m_phase)             m_remain = dur_tbl[np];
        else if (tk && m_phase != 8)   m_remain = m_remain - 1;
        m_phase = np;
        m_ten   = (np != 8);
    endtask

    task automatic compare_all();
        int exp_ns, exp_ew;
        exp_ns = (m_phase == 1) ? 3'b001 : (m_phase == 2) ? 3'b010 : 3'b100;
        exp_ew = (m_phase == 4) ? 3'b001 : (m_phase == 5) ? 3'b010 : 3'b100;
        check("phase",    int'(phase),    m_phase);
        check("remain",   int'(remain),   m_remain);
        check("ns_light", int'(ns_light), exp_ns);
        check("ew_light", int'(ew_light), exp_ew);
        check("walk",     int'(walk),     int'(m_phase == 7));
        check("ped_ack",  int'(ped_ack),  int'(m_ack));
        check("tick_en",  int'(tick_en),  int'(m_ten));
    endtask

    initial begin
        int rst_hold;
        model_reset();

        // Reset held with ticks arriving: state must stay at reset values.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tick_in = 1'b1;
            ped_req = 1'b1;
            @(posedge clk);
            #1;
            check("rst_phase",   int'(phase),    0);
            check("rst_ns",      int'(ns_light), 3'b100);
            check("rst_ew",      int'(ew_light), 3'b100);
            check("rst_remain",  int'(remain),   1);
            check("rst_tick_en", int'(tick_en),  0);
            check("rst_walk",    int'(walk),     0);
        end
        @(negedge clk);
        tick_in = 1'b0;
        ped_req = 1'b0;
        rst_n   = 1'b1;

        rst_hold = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            tick_in = ($urandom_range(0, 2) == 0);
            ped_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) emerg = ~emerg;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                rst_n    = 1'b0;
                rst_hold = $urandom_range(1, 3);
                model_reset();
                #1;
                check("async_rst_phase", int'(phase), 0);
                check("async_rst_walk",  int'(walk),  0);
            end
            if (rst_n) model_step(tick_in, ped_req, emerg);
            @(posedge clk);
            #1;
            compare_all();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
